// File: rtl/axi_sram_arb_controller_pkg.sv
// Shared AXI response codes and arbiter state encoding for the AXI-Lite SRAM controller.
package axi_sram_arb_controller_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrAccess,
        StWrResp,
        StRdAccess,
        StRdResp
    } arb_state_e;

endpackage

// File: rtl/axi_sram_arb_controller_sram_phy.sv
// SRAM pin driver: registered address/data/strobes, access-length counter and data tristate.
module axi_sram_arb_controller_sram_phy #(
    parameter int unsigned AW          = 20,
    parameter int unsigned DW          = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          write_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          done_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] sram_addr_o,
    inout  wire  [DW-1:0] sram_data_io,
    output logic          sram_we_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_ce_n_o
);

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          ce_n_q, ce_n_d;
    logic          we_n_q, we_n_d;
    logic          oe_n_q, oe_n_d;
    logic [3:0]    cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        ce_n_d = ce_n_q;
        we_n_d = we_n_q;
        oe_n_d = oe_n_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            addr_d = addr_i;
            data_d = wdata_i;
            ce_n_d = 1'b0;
            we_n_d = ~write_i;
            oe_n_d = write_i;
            cnt_d  = WaitCnt;
        end else if (!ce_n_q) begin
            // Final access cycle releases all strobes at its closing edge.
            if (cnt_q == 4'd0) begin
                ce_n_d = 1'b1;
                we_n_d = 1'b1;
                oe_n_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            data_q <= '0;
            ce_n_q <= 1'b1;
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            cnt_q  <= 4'd0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            ce_n_q <= ce_n_d;
            we_n_q <= we_n_d;
            oe_n_q <= oe_n_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done_o       = ~ce_n_q & (cnt_q == 4'd0);
    assign rdata_o      = sram_data_io;
    assign sram_addr_o  = addr_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_data_io = (!we_n_q) ? data_q : {DW{1'bz}};

endmodule

// File: rtl/axi_sram_arb_controller.sv
// AXI-Lite slave to asynchronous SRAM: one-entry skids on AW/W/AR and a round-robin
// read/write arbiter feeding a single SRAM access engine.
module axi_sram_arb_controller
    import axi_sram_arb_controller_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned STRB_MODE      = 0
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]       s_axi_wdata,
    input  logic [(AXI_DATA_WIDTH+7)/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [AXI_ADDR_WIDTH-1:0]       sram_addr,
    inout  wire  [AXI_DATA_WIDTH-1:0]       sram_data,
    output logic                            sram_we_n,
    output logic                            sram_oe_n,
    output logic                            sram_ce_n
);

    localparam int unsigned StrbW = (AXI_DATA_WIDTH + 7) / 8;

    arb_state_e                state_q, state_d;
    logic                      prio_wr_q, prio_wr_d;
    logic                      aw_full_q, aw_full_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                      w_full_q, w_full_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]          w_strb_q, w_strb_d;
    logic                      ar_full_q, ar_full_d;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                      phy_start, phy_write, phy_done;
    logic [AXI_ADDR_WIDTH-1:0] phy_addr;
    logic [AXI_DATA_WIDTH-1:0] phy_rdata;
    logic                      wr_pend, rd_pend, grant_wr, strb_err;

    assign wr_pend  = aw_full_q & w_full_q;
    assign rd_pend  = ar_full_q;
    assign grant_wr = wr_pend & (~rd_pend | prio_wr_q);
    assign strb_err = (STRB_MODE == 1) && (w_strb_q != {StrbW{1'b1}});

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_full_d = ar_full_q;
        ar_addr_d = ar_addr_q;
        bresp_d   = bresp_q;
        rdata_d   = rdata_q;
        phy_start = 1'b0;
        phy_write = 1'b0;
        phy_addr  = aw_addr_q;

        if (s_axi_awvalid && s_axi_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end
        if (s_axi_wvalid && s_axi_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (s_axi_arvalid && s_axi_arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_axi_araddr;
        end

        unique case (state_q)
            StIdle: begin
                // Skids are released on grant so the next request can queue behind this one.
                if (grant_wr) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    prio_wr_d = 1'b0;
                    if (strb_err) begin
                        bresp_d = RESP_SLVERR;
                        state_d = StWrResp;
                    end else begin
                        bresp_d   = RESP_OKAY;
                        phy_start = 1'b1;
                        phy_write = 1'b1;
                        state_d   = StWrAccess;
                    end
                end else if (rd_pend) begin
                    ar_full_d = 1'b0;
                    prio_wr_d = 1'b1;
                    phy_start = 1'b1;
                    phy_addr  = ar_addr_q;
                    state_d   = StRdAccess;
                end
            end
            StWrAccess: if (phy_done) state_d = StWrResp;
            StWrResp:   if (s_axi_bready) state_d = StIdle;
            StRdAccess: begin
                if (phy_done) begin
                    rdata_d = phy_rdata;
                    state_d = StRdResp;
                end
            end
            StRdResp:   if (s_axi_rready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= StIdle;
            prio_wr_q <= 1'b1;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_full_q <= ar_full_d;
            ar_addr_q <= ar_addr_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Readies are held low while reset is asserted.
    assign s_axi_awready = axi_aresetn & ~aw_full_q;
    assign s_axi_wready  = axi_aresetn & ~w_full_q;
    assign s_axi_arready = axi_aresetn & ~ar_full_q;
    assign s_axi_bvalid  = (state_q == StWrResp);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (state_q == StRdResp);
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rdata   = rdata_q;

    axi_sram_arb_controller_sram_phy #(
        .AW          (AXI_ADDR_WIDTH),
        .DW          (AXI_DATA_WIDTH),
        .WAIT_STATES (WAIT_STATES)
    ) u_sram_phy (
        .clk_i        (axi_aclk),
        .rst_ni       (axi_aresetn),
        .start_i      (phy_start),
        .write_i      (phy_write),
        .addr_i       (phy_addr),
        .wdata_i      (w_data_q),
        .done_o       (phy_done),
        .rdata_o      (phy_rdata),
        .sram_addr_o  (sram_addr),
        .sram_data_io (sram_data),
        .sram_we_n_o  (sram_we_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_ce_n_o  (sram_ce_n)
    );

endmodule

// File: tb/tb_axi_sram_arb_controller.sv
// Directed bench: two controller instances (no wait states; 3 wait states with strobe
// checking), each with a small SRAM model on its pins.
module tb_axi_sram_arb_controller;

    int vec  = 0;
    int errs = 0;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [19:0] awaddr [2];
    logic        awvalid[2];
    logic        awready[2];
    logic [15:0] wdata  [2];
    logic [1:0]  wstrb  [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [1:0]  bresp  [2];
    logic        bvalid [2];
    logic        bready [2];
    logic [19:0] araddr [2];
    logic        arvalid[2];
    logic        arready[2];
    logic [15:0] rdata  [2];
    logic [1:0]  rresp  [2];
    logic        rvalid [2];
    logic        rready [2];
    logic [19:0] sa     [2];
    logic        we_n   [2];
    logic        oe_n   [2];
    logic        ce_n   [2];
    wire  [15:0] sd0, sd1;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    assign sd0 = (!ce_n[0] && !oe_n[0]) ? mem0[sa[0][7:0]] : 16'hzzzz;
    assign sd1 = (!ce_n[1] && !oe_n[1]) ? mem1[sa[1][7:0]] : 16'hzzzz;

    int          n_acc0 = 0;
    int          n_we1  = 0;
    int          n_oe1  = 0;
    logic [15:0] log0   = '0;

    always @(posedge clk) begin
        if (!ce_n[0] && !we_n[0]) mem0[sa[0][7:0]] <= sd0;
        if (!ce_n[1] && !we_n[1]) mem1[sa[1][7:0]] <= sd1;
        if (!ce_n[0]) begin
            n_acc0 <= n_acc0 + 1;
            log0   <= {log0[14:0], we_n[0]};
        end
        if (!we_n[1]) n_we1 <= n_we1 + 1;
        if (!oe_n[1]) n_oe1 <= n_oe1 + 1;
    end

    axi_sram_arb_controller #(
        .AXI_ADDR_WIDTH (20),
        .AXI_DATA_WIDTH (16),
        .WAIT_STATES    (0),
        .STRB_MODE      (0)
    ) u_dut0 (
        .axi_aclk      (clk),
        .axi_aresetn   (rstn),
        .s_axi_awaddr  (awaddr[0]),
        .s_axi_awvalid (awvalid[0]),
        .s_axi_awready (awready[0]),
        .s_axi_wdata   (wdata[0]),
        .s_axi_wstrb   (wstrb[0]),
        .s_axi_wvalid  (wvalid[0]),
        .s_axi_wready  (wready[0]),
        .s_axi_bresp   (bresp[0]),
        .s_axi_bvalid  (bvalid[0]),
        .s_axi_bready  (bready[0]),
        .s_axi_araddr  (araddr[0]),
        .s_axi_arvalid (arvalid[0]),
        .s_axi_arready (arready[0]),
        .s_axi_rdata   (rdata[0]),
        .s_axi_rresp   (rresp[0]),
        .s_axi_rvalid  (rvalid[0]),
        .s_axi_rready  (rready[0]),
        .sram_addr     (sa[0]),
        .sram_data     (sd0),
        .sram_we_n     (we_n[0]),
        .sram_oe_n     (oe_n[0]),
        .sram_ce_n     (ce_n[0])
    );

    axi_sram_arb_controller #(
        .AXI_ADDR_WIDTH (20),
        .AXI_DATA_WIDTH (16),
        .WAIT_STATES    (3),
        .STRB_MODE      (1)
    ) u_dut1 (
        .axi_aclk      (clk),
        .axi_aresetn   (rstn),
        .s_axi_awaddr  (awaddr[1]),
        .s_axi_awvalid (awvalid[1]),
        .s_axi_awready (awready[1]),
        .s_axi_wdata   (wdata[1]),
        .s_axi_wstrb   (wstrb[1]),
        .s_axi_wvalid  (wvalid[1]),
        .s_axi_wready  (wready[1]),
        .s_axi_bresp   (bresp[1]),
        .s_axi_bvalid  (bvalid[1]),
        .s_axi_bready  (bready[1]),
        .s_axi_araddr  (araddr[1]),
        .s_axi_arvalid (arvalid[1]),
        .s_axi_arready (arready[1]),
        .s_axi_rdata   (rdata[1]),
        .s_axi_rresp   (rresp[1]),
        .s_axi_rvalid  (rvalid[1]),
        .s_axi_rready  (rready[1]),
        .sram_addr     (sa[1]),
        .sram_data     (sd1),
        .sram_we_n     (we_n[1]),
        .sram_oe_n     (oe_n[1]),
        .sram_ce_n     (ce_n[1])
    );

    // Issues AW and W together; lat = negedges from the last handshake edge to bvalid.
    task automatic do_write(input int d, input logic [19:0] a, input logic [15:0] data,
                            input logic [1:0] strb, output logic [1:0] resp, output int lat);
        bit aw_done = 0;
        bit w_done  = 0;
        int t       = 0;
        awaddr[d] = a; wdata[d] = data; wstrb[d] = strb;
        awvalid[d] = 1'b1; wvalid[d] = 1'b1;
        while (!(aw_done && w_done) && t < 50) begin
            if (awvalid[d] && awready[d]) aw_done = 1;
            if (wvalid[d] && wready[d]) w_done = 1;
            @(negedge clk);
            if (aw_done) awvalid[d] = 1'b0;
            if (w_done) wvalid[d] = 1'b0;
            t++;
        end
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        if (!(aw_done && w_done)) begin
            vec++; errs++;
            $display("FAIL wr_handshake_timeout dut%0d: got aw=%0b w=%0b want 1 1", d, aw_done, w_done);
        end
        lat = 0;
        while (!bvalid[d] && lat < 60) begin @(negedge clk); lat++; end
        if (!bvalid[d]) begin
            vec++; errs++;
            $display("FAIL bvalid_timeout dut%0d: got bvalid=0 want 1", d);
        end
        resp = bresp[d];
        @(negedge clk);
    endtask

    task automatic do_read(input int d, input logic [19:0] a, output logic [15:0] data,
                           output int lat);
        int t = 0;
        araddr[d] = a; arvalid[d] = 1'b1;
        while (!arready[d] && t < 50) begin @(negedge clk); t++; end
        if (!arready[d]) begin
            vec++; errs++;
            $display("FAIL ar_handshake_timeout dut%0d: got arready=0 want 1", d);
        end
        @(negedge clk);
        arvalid[d] = 1'b0;
        lat = 0;
        while (!rvalid[d] && lat < 60) begin @(negedge clk); lat++; end
        if (!rvalid[d]) begin
            vec++; errs++;
            $display("FAIL rvalid_timeout dut%0d: got rvalid=0 want 1", d);
        end
        data = rdata[d];
        vec++;
        if (rresp[d] !== 2'b00) begin
            errs++; $display("FAIL rresp dut%0d: got %0h want 0", d, rresp[d]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vec++;
            if ({awready[d], wready[d], arready[d], bvalid[d], rvalid[d]} !== 5'b0) begin
                errs++; $display("FAIL reset_handshake dut%0d: got %b want 00000", d,
                    {awready[d], wready[d], arready[d], bvalid[d], rvalid[d]});
            end
            vec++;
            if ({ce_n[d], we_n[d], oe_n[d]} !== 3'b111) begin
                errs++; $display("FAIL reset_strobes dut%0d: got %b want 111", d,
                    {ce_n[d], we_n[d], oe_n[d]});
            end
            vec++;
            if (sa[d] !== 20'h0 || rdata[d] !== 16'h0 || {bresp[d], rresp[d]} !== 4'h0) begin
                errs++; $display("FAIL reset_regs dut%0d: got addr=%0h rdata=%0h resp=%0h want 0 0 0",
                    d, sa[d], rdata[d], {bresp[d], rresp[d]});
            end
        end
        rstn = 1'b1;
        #1;
        vec++;
        if ({awready[0], wready[0], arready[0]} !== 3'b111) begin
            errs++; $display("FAIL post_reset_ready: got %b want 111",
                {awready[0], wready[0], arready[0]});
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [15:0] data;
        int          lat;
        do_write(0, 20'h00010, 16'hBEEF, 2'b11, resp, lat);
        vec++;
        if (resp !== 2'b00 || lat != 2) begin
            errs++; $display("FAIL basic_write: got bresp=%0h lat=%0d want 0 2", resp, lat);
        end
        vec++;
        if (mem0[8'h10] !== 16'hBEEF) begin
            errs++; $display("FAIL basic_mem: got %0h want beef", mem0[8'h10]);
        end
        do_read(0, 20'h00010, data, lat);
        vec++;
        if (data !== 16'hBEEF || lat != 2) begin
            errs++; $display("FAIL basic_read: got rdata=%0h lat=%0d want beef 2", data, lat);
        end
        vec++;
        if (rvalid[0] !== 1'b0 || bvalid[0] !== 1'b0) begin
            errs++; $display("FAIL basic_resp_cleared: got r=%0b b=%0b want 0 0", rvalid[0], bvalid[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  wr_resp [2];
        logic [15:0] rd_data [2];
        int          n0;
        n0 = n_acc0;
        fork
            begin
                int l;
                do_write(0, 20'h00030, 16'hA5A5, 2'b11, wr_resp[0], l);
                do_write(0, 20'h00031, 16'h5A5A, 2'b11, wr_resp[1], l);
            end
            begin
                int l;
                do_read(0, 20'h00010, rd_data[0], l);
                do_read(0, 20'h00030, rd_data[1], l);
            end
        join
        vec++;
        if (n_acc0 - n0 != 4 || log0[3:0] !== 4'b0101) begin
            errs++; $display("FAIL arb_order: got accesses=%0d order=%b want 4 0101",
                n_acc0 - n0, log0[3:0]);
        end
        vec++;
        if (rd_data[0] !== 16'hBEEF || rd_data[1] !== 16'hA5A5) begin
            errs++; $display("FAIL arb_rdata: got %0h %0h want beef a5a5", rd_data[0], rd_data[1]);
        end
        vec++;
        if (wr_resp[0] !== 2'b00 || wr_resp[1] !== 2'b00 || mem0[8'h31] !== 16'h5A5A) begin
            errs++; $display("FAIL arb_writes: got %0h %0h mem=%0h want 0 0 5a5a",
                wr_resp[0], wr_resp[1], mem0[8'h31]);
        end
    endtask

    task automatic test_w_before_aw();
        int n0;
        int lat;
        n0 = n_acc0;
        wdata[0] = 16'h1234; wstrb[0] = 2'b11; wvalid[0] = 1'b1;
        vec++;
        if (wready[0] !== 1'b1) begin
            errs++; $display("FAIL early_w_ready: got %0b want 1", wready[0]);
        end
        @(negedge clk);
        wvalid[0] = 1'b0;
        vec++;
        if (wready[0] !== 1'b0) begin
            errs++; $display("FAIL early_w_held: got wready=%0b want 0", wready[0]);
        end
        repeat (2) @(negedge clk);
        vec++;
        if (n_acc0 != n0 || ce_n[0] !== 1'b1) begin
            errs++; $display("FAIL early_w_no_access: got accesses=%0d ce_n=%0b want 0 1",
                n_acc0 - n0, ce_n[0]);
        end
        awaddr[0] = 20'h00020; awvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0;
        lat = 0;
        while (!bvalid[0] && lat < 20) begin @(negedge clk); lat++; end
        vec++;
        if (bvalid[0] !== 1'b1 || lat != 2 || bresp[0] !== 2'b00) begin
            errs++; $display("FAIL early_w_resp: got bvalid=%0b lat=%0d bresp=%0h want 1 2 0",
                bvalid[0], lat, bresp[0]);
        end
        @(negedge clk);
        vec++;
        if (n_acc0 - n0 != 1 || mem0[8'h20] !== 16'h1234) begin
            errs++; $display("FAIL early_w_single: got accesses=%0d mem=%0h want 1 1234",
                n_acc0 - n0, mem0[8'h20]);
        end
    endtask

    task automatic test_wait_states();
        logic [1:0]  resp;
        logic [15:0] data;
        int          lat, nw, no;
        nw = n_we1;
        do_write(1, 20'h00040, 16'h7777, 2'b11, resp, lat);
        vec++;
        if (resp !== 2'b00 || lat != 5 || n_we1 - nw != 4) begin
            errs++; $display("FAIL ws_write: got bresp=%0h lat=%0d we_cycles=%0d want 0 5 4",
                resp, lat, n_we1 - nw);
        end
        no = n_oe1;
        do_read(1, 20'h00040, data, lat);
        vec++;
        if (data !== 16'h7777 || lat != 5 || n_oe1 - no != 4) begin
            errs++; $display("FAIL ws_read: got rdata=%0h lat=%0d oe_cycles=%0d want 7777 5 4",
                data, lat, n_oe1 - no);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [15:0] data;
        int          lat, nw;
        nw = n_we1;
        do_write(1, 20'h00040, 16'h0001, 2'b01, resp, lat);
        vec++;
        if (resp !== 2'b10 || lat != 1) begin
            errs++; $display("FAIL strb_resp: got bresp=%0h lat=%0d want 2 1", resp, lat);
        end
        vec++;
        if (n_we1 != nw) begin
            errs++; $display("FAIL strb_no_we: got we_cycles=%0d want 0", n_we1 - nw);
        end
        do_read(1, 20'h00040, data, lat);
        vec++;
        if (data !== 16'h7777) begin
            errs++; $display("FAIL strb_readback: got %0h want 7777", data);
        end
    endtask

    task automatic test_reset_mid_access();
        int t = 0;
        bit stable = 1;
        bit leak = 0;
        bready[0] = 1'b0;
        awaddr[0] = 20'h00050; wdata[0] = 16'h1111; wstrb[0] = 2'b11;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        while (!bvalid[0] && t < 20) begin @(negedge clk); t++; end
        // Queue a second write behind the stalled response.
        awaddr[0] = 20'h00051; wdata[0] = 16'h2222;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b00) stable = 0;
            @(negedge clk);
            awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        end
        vec++;
        if (!stable || bvalid[0] !== 1'b1 || awready[0] !== 1'b0) begin
            errs++; $display("FAIL bresp_hold: got stable=%0b bvalid=%0b awready=%0b want 1 1 0",
                stable, bvalid[0], awready[0]);
        end
        bready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vec++;
        if ({ce_n[0], we_n[0]} !== 2'b00 || sa[0] !== 20'h00051) begin
            errs++; $display("FAIL second_write_access: got ce_n/we_n=%b addr=%0h want 00 51",
                {ce_n[0], we_n[0]}, sa[0]);
        end
        rstn = 1'b0;
        #1;
        vec++;
        if ({ce_n[0], we_n[0], oe_n[0]} !== 3'b111 || sa[0] !== 20'h0 || rdata[0] !== 16'h0) begin
            errs++; $display("FAIL abort_pins: got strobes=%b addr=%0h rdata=%0h want 111 0 0",
                {ce_n[0], we_n[0], oe_n[0]}, sa[0], rdata[0]);
        end
        vec++;
        if ({awready[0], wready[0], arready[0], bvalid[0], rvalid[0]} !== 5'b0) begin
            errs++; $display("FAIL abort_handshake: got %b want 00000",
                {awready[0], wready[0], arready[0], bvalid[0], rvalid[0]});
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bvalid[0] || !ce_n[0]) leak = 1;
        end
        vec++;
        if (leak || awready[0] !== 1'b1) begin
            errs++; $display("FAIL post_abort: got stray_activity=%0b awready=%0b want 0 1",
                leak, awready[0]);
        end
    endtask

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = 2'b11;
            wvalid[d] = 1'b0; bready[d] = 1'b1; araddr[d] = '0; arvalid[d] = 1'b0;
            rready[d] = 1'b1;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_w_before_aw();
        test_wait_states();
        test_strobe();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/axi_sram_arb_controller.md
AXI_SRAM_ARB_CONTROLLER -- requirements
Module: axi_sram_arb_controller

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 20, SRAM word address width (AXI address used directly as word address).
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 16, data width.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra SRAM access cycles, legal 0..15.
REQ-004 SHALL have parameter STRB_MODE, default 0: 0 = ignore wstrb; 1 = partial wstrb rejected with SLVERR.
REQ-005 SHALL have ports: axi_aclk in 1 clock; axi_aresetn in 1 reset; reset axi_aresetn is asynchronous, active-low; clock axi_aclk.
REQ-006 SHALL have AXI-Lite write ports: s_axi_awaddr in AW, s_axi_awvalid in 1, s_axi_awready out 1, s_axi_wdata in DW, s_axi_wstrb in (DW+7)/8, s_axi_wvalid in 1, s_axi_wready out 1, s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1.
REQ-007 SHALL have AXI-Lite read ports: s_axi_araddr in AW, s_axi_arvalid in 1, s_axi_arready out 1, s_axi_rdata out DW, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-008 SHALL have SRAM ports: sram_addr out AW, sram_data inout DW, sram_we_n out 1, sram_oe_n out 1, sram_ce_n out 1.

Function
REQ-009 SHALL hold AW, W and AR each in an independent one-entry skid register; awready/wready/arready = corresponding register empty; AW and W need not arrive in the same cycle.
REQ-010 SHALL treat a write as pending when both AW and W registers are full; read pending when AR register full.
REQ-011 SHALL run FSM IDLE, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP; IDLE->WR_ACCESS or RD_ACCESS on pending request, ACCESS->RESP after access count, RESP->IDLE on bready/rready handshake.
REQ-012 SHALL arbitrate in IDLE: single pending wins; both pending -> round-robin, priority toggling after each grant; write has priority after reset.
REQ-013 SHALL last exactly 1+WAIT_STATES cycles in each ACCESS state, counted by a 4-bit counter.
REQ-014 Write access: sram_ce_n=0, sram_we_n=0, sram_oe_n=1, sram_addr=awaddr, sram_data driven with wdata for all access cycles.
REQ-015 Read access: sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_data hi-Z; rdata registered at the final access cycle edge.
REQ-016 Outside ACCESS states: ce_n/we_n/oe_n=1, sram_data hi-Z.
REQ-017 SHALL free AW+W registers (or AR) on entering ACCESS, so next request can be accepted during access/response.
REQ-018 Latency: request pending at edge N -> access cycles N+1..N+1+WAIT_STATES -> bvalid/rvalid high from edge N+2+WAIT_STATES.
REQ-019 bvalid/rvalid, bresp/rresp, rdata SHALL be registered and stable until handshake.
REQ-020 bresp/rresp SHALL be OKAY (00) except STRB_MODE=1 with wstrb not all-ones: no SRAM cycle, IDLE->WR_RESP directly, bresp=SLVERR (10).
REQ-021 Simultaneous arrival of AW, W and AR in IDLE with priority at write: write granted, then read, no request lost.

Reset
REQ-022 During reset SHALL force: awready/wready/arready=0, bvalid/rvalid=0, bresp/rresp=00, rdata=0, sram_addr=0, ce_n/we_n/oe_n=1, sram_data hi-Z, FSM=IDLE, skid registers empty, priority=write.
REQ-023 Reset asserted mid-access SHALL abort immediately (asynchronously); transaction discarded, no response issued.
REQ-024 First cycle after reset release: awready/wready/arready=1.

Structure
REQ-025 RESP_OKAY/RESP_SLVERR constants SHALL live in the shared AXI defines include, not local to this module.
REQ-026 SRAM pin timing and tristate SHALL be in sub-module sram_phy (addr/data/strobe registers, WAIT_STATES counter); FSM, skids, arbiter in top.

Verification
REQ-027 Write 0x00010 data 0xBEEF then read 0x00010, WAIT_STATES=0 -> bresp=00, rdata=0xBEEF, rvalid two cycles after arvalid accepted.
REQ-028 W valid 3 cycles before AW for addr 0x00020 data 0x1234 -> wready handshake at cycle 0, no SRAM cycle until AW arrives, then single write.
REQ-029 AW+W and AR asserted together continuously for 4 transactions -> grants alternate W,R,W,R.
REQ-030 WAIT_STATES=3, read -> oe_n low exactly 4 cycles, rvalid at N+5.
REQ-031 STRB_MODE=1, wstrb=01 -> bresp=10, we_n never low, memory unchanged on readback.
REQ-032 bready held low 10 cycles, then reset mid-write-access -> all outputs at reset values, no bvalid after release.
